lsm_sequencer: RTL and testbench
================================

Name: lsm_sequencer

Overview:
Multi-cycle controller for ARM Load/Store Multiple (IR[27:25]=3'b100). It walks the 16-bit register list lowest-to-highest and issues one memory transfer per listed register, using the 4*popcount offset convention the datapath already applies for LSM operands. It then issues a base-register writeback request and a completion pulse. It sits between the decode/control unit and the register file / memory interface.

Parameters:
ADDR_W, 32, address and base width
WORD_BYTES, 4, address stride per transferred register

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
START  input  1  one-cycle request to execute the instruction in IR
IR  input  32  instruction word
BASE  input  ADDR_W  current value of Rn (IR[19:16]), sampled in IDLE with START
MEM_ACK  input  1  memory accepted/completed the current transfer
BUSY  output  1  high from the cycle after accepted START until DONE
XFER_VALID  output  1  transfer request valid
XFER_LOAD  output  1  1 = load (L bit), 0 = store; valid with XFER_VALID
REG_SEL  output  4  register number for the current transfer
ADDR  output  ADDR_W  word address for the current transfer
WB_VALID  output  1  one-cycle base writeback strobe
WB_REG  output  4  writeback target (= IR[19:16])
WB_DATA  output  ADDR_W  new base value
DONE  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous, active-low (RESET_N).
- Reset values: state=IDLE; all outputs 0.
- Reset asserted mid-operation abandons the instruction immediately. No WB_VALID or DONE is issued for it.
- IDLE: START=1 with IR[27:25]=3'b100 latches IR and BASE, then goes to SETUP. START with any other opcode is ignored. START while BUSY is ignored.
- SETUP (1 cycle): pending mask = IR[15:0]; n = popcount (0..16, 5 bits).
- Start address from P=IR[24], U=IR[23]:
  - IA (P0 U1): BASE
  - IB (P1 U1): BASE+4
  - DA (P0 U0): BASE−4n+4
  - DB (P1 U0): BASE−4n
- Writeback value: U=1 gives BASE+4n; U=0 gives BASE−4n.
- Address arithmetic is modulo 2^ADDR_W (wrap-around, no flag).
- n=0 goes to DONE: no transfers, no writeback.
- XFER: XFER_VALID=1; REG_SEL = lowest set bit of pending; ADDR = current address.
  - REG_SEL, ADDR and XFER_LOAD hold stable until MEM_ACK.
  - On MEM_ACK: clear that bit and add 4 to the address.
  - If no pending bits remain, go to WBACK when W=IR[21]=1, else to DONE. Otherwise stay in XFER, with the next register presented the following cycle.
  - Back-to-back MEM_ACK gives 1 transfer per cycle.
- WBACK (1 cycle): WB_VALID=1, WB_REG=Rn, WB_DATA=writeback value.
  - Exception: when L=1 and Rn is in the list, WB_VALID stays 0 (the loaded value wins). The state still consumes the cycle.
- DONE (1 cycle): DONE=1, BUSY=0 in the same cycle, then IDLE. A new START is accepted in IDLE the cycle after DONE.
- Latency with MEM_ACK always high: START cycle T, SETUP T+1, transfers T+2..T+n+1, WBACK T+n+2 (if W), DONE next.
- S bit (IR[22]) is ignored (no user-bank transfer).

Optional Feature:
LSM_PC_FLUSH_EN
- Defined: adds output FLUSH (1 bit, reset 0). FLUSH pulses together with DONE when L=1 and IR[15]=1 (load to PC), requesting a pipeline refill.
- Undefined: no FLUSH port; behaviour otherwise identical.

Decomposition:
- Shared package arm_pkg holds:
  - state enum {IDLE, SETUP, XFER, WBACK, DONE}
  - addressing-mode constants IA/IB/DA/DB
  - opcode class constant LSM_CLASS=3'b100
  - WORD_BYTES
- One sub-module is natural: reg_list_encoder (16-bit lowest-set-bit priority encoder with valid flag, plus popcount). It is reused by decode.

Test Plan:
- STMIA R0!,{R1,R2,R4}: IR=0xE8A00016, BASE=0x1000, MEM_ACK=1.
  - Required: REG_SEL 1/2/4 at ADDR 0x1000/0x1004/0x1008, XFER_LOAD=0.
  - Then WB_VALID with WB_REG=0, WB_DATA=0x100C; DONE at T+6.
- LDMDB R13!,{R0,PC}: IR=0xE93D8001, BASE=0x2000.
  - Required: R0@0x1FF8, R15@0x1FFC, XFER_LOAD=1, WB_DATA=0x1FF8.
  - FLUSH pulses with DONE when LSM_PC_FLUSH_EN is defined.
- Empty list: IR=0xE8900000 → no XFER_VALID, no WB_VALID; DONE at T+2.
- Stall: MEM_ACK low 3 cycles during the first transfer of an LDMIB with BASE=0x0 → ADDR=0x4 and REG_SEL held stable; sequence resumes on ACK.
- Rn in list with load: LDMIA R2!,{R2,R3} (IR=0xE8B2000C) → 2 transfers; WB_VALID stays 0; DONE still issued.
- RESET_N low during the second XFER cycle → all outputs 0 immediately. START with IR=0xE0810002 (not LSM) after reset is ignored: BUSY stays 0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM control definitions: LSM sequencer states, addressing modes and opcode class.
package arm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WBACK,
        S_DONE
    } lsm_state_t;

    // Addressing modes encoded as {P, U}
    localparam logic [1:0] IA = 2'b01;
    localparam logic [1:0] IB = 2'b11;
    localparam logic [1:0] DA = 2'b00;
    localparam logic [1:0] DB = 2'b10;

    localparam logic [2:0] LSM_CLASS  = 3'b100;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/reg_list_encoder.sv
// Lowest-set-bit priority encoder with valid flag and popcount over a 16-bit register list.
module reg_list_encoder (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic        valid,
    output logic [4:0]  count
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        count = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (mask[i]) begin
                count = count + 5'd1;
                if (!valid) begin
                    idx   = 4'(i);
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lsm_sequencer.sv
// ARM Load/Store Multiple sequencer: one transfer per listed register, then writeback and DONE.
// Optional LSM_PC_FLUSH_EN adds a FLUSH pulse alongside DONE for loads that include the PC.
module lsm_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = arm_pkg::WORD_BYTES
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] BASE,
    input  logic              MEM_ACK,
    output logic              BUSY,
    output logic              XFER_VALID,
    output logic              XFER_LOAD,
    output logic [3:0]        REG_SEL,
    output logic [ADDR_W-1:0] ADDR,
    output logic              WB_VALID,
    output logic [3:0]        WB_REG,
    output logic [ADDR_W-1:0] WB_DATA,
    output logic              DONE
`ifdef LSM_PC_FLUSH_EN
    ,
    output logic              FLUSH
`endif
);

    import arm_pkg::*;

    lsm_state_t        state;
    logic [15:0]       pending;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] wb_q;
    logic [3:0]        rn_q;
    logic              p_q, u_q, w_q, l_q, rn_hit_q;

    logic              accept;
    logic [15:0]       enc_in;
    logic [3:0]        enc_idx;
    logic              enc_valid;
    logic [4:0]        enc_count;
    logic [ADDR_W-1:0] stride, offs, start_addr, wb_val;
    logic              unused_ir;

    assign unused_ir = ^{IR[31:28], IR[22]};
    assign accept    = START && (IR[27:25] == LSM_CLASS);
    assign stride    = ADDR_W'(WORD_BYTES);
    assign offs      = ADDR_W'(enc_count) * stride;

    // In XFER the encoder looks ahead past the register being presented so the
    // next REG_SEL can be registered on the same MEM_ACK edge.
    always_comb begin
        enc_in = pending;
        if (state == S_XFER)
            enc_in = pending & ~(16'd1 << REG_SEL);
    end

    reg_list_encoder u_enc (
        .mask  (enc_in),
        .idx   (enc_idx),
        .valid (enc_valid),
        .count (enc_count)
    );

    always_comb begin
        start_addr = base_q - offs;
        case ({p_q, u_q})
            IA:      start_addr = base_q;
            IB:      start_addr = base_q + stride;
            DA:      start_addr = base_q - offs + stride;
            DB:      start_addr = base_q - offs;
            default: start_addr = base_q - offs;
        endcase
        wb_val = u_q ? (base_q + offs) : (base_q - offs);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            pending    <= '0;
            base_q     <= '0;
            wb_q       <= '0;
            rn_q       <= '0;
            p_q        <= 1'b0;
            u_q        <= 1'b0;
            w_q        <= 1'b0;
            l_q        <= 1'b0;
            rn_hit_q   <= 1'b0;
            BUSY       <= 1'b0;
            XFER_VALID <= 1'b0;
            XFER_LOAD  <= 1'b0;
            REG_SEL    <= '0;
            ADDR       <= '0;
            WB_VALID   <= 1'b0;
            WB_REG     <= '0;
            WB_DATA    <= '0;
            DONE       <= 1'b0;
        end else begin
            WB_VALID <= 1'b0;
            DONE     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        pending  <= IR[15:0];
                        base_q   <= BASE;
                        rn_q     <= IR[19:16];
                        p_q      <= IR[24];
                        u_q      <= IR[23];
                        w_q      <= IR[21];
                        l_q      <= IR[20];
                        rn_hit_q <= IR[IR[19:16]];
                        BUSY     <= 1'b1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wb_q <= wb_val;
                    if (enc_valid) begin
                        XFER_VALID <= 1'b1;
                        XFER_LOAD  <= l_q;
                        REG_SEL    <= enc_idx;
                        ADDR       <= start_addr;
                        state      <= S_XFER;
                    end else begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_XFER: begin
                    if (MEM_ACK) begin
                        pending <= enc_in;
                        if (enc_valid) begin
                            REG_SEL <= enc_idx;
                            ADDR    <= ADDR + stride;
                        end else begin
                            XFER_VALID <= 1'b0;
                            XFER_LOAD  <= 1'b0;
                            REG_SEL    <= '0;
                            ADDR       <= '0;
                            if (w_q) begin
                                // A load that includes Rn keeps the loaded value
                                if (!(l_q && rn_hit_q)) begin
                                    WB_VALID <= 1'b1;
                                    WB_REG   <= rn_q;
                                    WB_DATA  <= wb_q;
                                end
                                state <= S_WBACK;
                            end else begin
                                DONE  <= 1'b1;
                                BUSY  <= 1'b0;
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_WBACK: begin
                    WB_REG  <= '0;
                    WB_DATA <= '0;
                    DONE    <= 1'b1;
                    BUSY    <= 1'b0;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LSM_PC_FLUSH_EN
    logic pc_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            pc_q <= 1'b0;
        else if (state == S_IDLE && accept)
            pc_q <= IR[15];
    end

    assign FLUSH = DONE & l_q & pc_q;
`endif

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed self-checking bench for lsm_sequencer (checks FLUSH when LSM_PC_FLUSH_EN is defined).
module tb_lsm_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] ir;
    logic [31:0] base;
    logic        mem_ack;
    logic        busy, xfer_valid, xfer_load, wb_valid, done;
    logic [3:0]  reg_sel, wb_reg;
    logic [31:0] addr, wb_data;
`ifdef LSM_PC_FLUSH_EN
    logic        flush;
`endif

    int errors = 0;
    int checks = 0;

    lsm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .START      (start),
        .IR         (ir),
        .BASE       (base),
        .MEM_ACK    (mem_ack),
        .BUSY       (busy),
        .XFER_VALID (xfer_valid),
        .XFER_LOAD  (xfer_load),
        .REG_SEL    (reg_sel),
        .ADDR       (addr),
        .WB_VALID   (wb_valid),
        .WB_REG     (wb_reg),
        .WB_DATA    (wb_data),
        .DONE       (done)
`ifdef LSM_PC_FLUSH_EN
        ,
        .FLUSH      (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_xfer(input string tag, input logic [3:0] sel, input logic [31:0] a, input logic ld);
        chk({tag, ".valid"}, 64'(xfer_valid), 64'd1);
        chk({tag, ".sel"},   64'(reg_sel),    64'(sel));
        chk({tag, ".addr"},  64'(addr),       64'(a));
        chk({tag, ".load"},  64'(xfer_load),  64'(ld));
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] b);
        ir    = i;
        base  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        ir      = '0;
        base    = '0;
        mem_ack = 1'b1;
        tick();
        tick();
        chk("rst.busy",  64'(busy),       64'd0);
        chk("rst.xv",    64'(xfer_valid), 64'd0);
        chk("rst.addr",  64'(addr),       64'd0);
        chk("rst.wbv",   64'(wb_valid),   64'd0);
        chk("rst.done",  64'(done),       64'd0);
        rst_n = 1'b1;
        tick();

        // STMIA R0!,{R1,R2,R4}
        issue(32'hE8A00016, 32'h1000);
        chk("stm.setup.busy", 64'(busy),       64'd1);
        chk("stm.setup.xv",   64'(xfer_valid), 64'd0);
        tick(); chk_xfer("stm.x0", 4'd1, 32'h1000, 1'b0);
        tick(); chk_xfer("stm.x1", 4'd2, 32'h1004, 1'b0);
        tick(); chk_xfer("stm.x2", 4'd4, 32'h1008, 1'b0);
        tick();
        chk("stm.wb.xv",   64'(xfer_valid), 64'd0);
        chk("stm.wb.v",    64'(wb_valid),   64'd1);
        chk("stm.wb.reg",  64'(wb_reg),     64'd0);
        chk("stm.wb.data", 64'(wb_data),    64'h100C);
        chk("stm.wb.done", 64'(done),       64'd0);
        tick();
        chk("stm.done",      64'(done),     64'd1);
        chk("stm.done.busy", 64'(busy),     64'd0);
        chk("stm.done.wbv",  64'(wb_valid), 64'd0);
        tick();
        chk("stm.idle.done", 64'(done),     64'd0);

        // LDMDB R13!,{R0,PC}
        issue(32'hE93D8001, 32'h2000);
        tick(); chk_xfer("ldmdb.x0", 4'd0,  32'h1FF8, 1'b1);
        tick(); chk_xfer("ldmdb.x1", 4'd15, 32'h1FFC, 1'b1);
`ifdef LSM_PC_FLUSH_EN
        chk("ldmdb.flush.early", 64'(flush), 64'd0);
`endif
        tick();
        chk("ldmdb.wb.v",    64'(wb_valid), 64'd1);
        chk("ldmdb.wb.reg",  64'(wb_reg),   64'd13);
        chk("ldmdb.wb.data", 64'(wb_data),  64'h1FF8);
        tick();
        chk("ldmdb.done", 64'(done), 64'd1);
`ifdef LSM_PC_FLUSH_EN
        chk("ldmdb.flush", 64'(flush), 64'd1);
`endif
        tick();

        // Empty list
        issue(32'hE8900000, 32'h5000);
        chk("empty.setup.xv", 64'(xfer_valid), 64'd0);
        chk("empty.setup.busy", 64'(busy),     64'd1);
        tick();
        chk("empty.done", 64'(done),       64'd1);
        chk("empty.xv",   64'(xfer_valid), 64'd0);
        chk("empty.wbv",  64'(wb_valid),   64'd0);
        chk("empty.busy", 64'(busy),       64'd0);
        tick();

        // LDMIB R1,{R3,R5} with a 3-cycle stall on the first transfer
        issue(32'hE9910028, 32'h0);
        mem_ack = 1'b0;
        tick(); chk_xfer("stall.c0", 4'd3, 32'h4, 1'b1);
        tick(); chk_xfer("stall.c1", 4'd3, 32'h4, 1'b1);
        tick(); chk_xfer("stall.c2", 4'd3, 32'h4, 1'b1);
        mem_ack = 1'b1;
        tick(); chk_xfer("stall.x1", 4'd5, 32'h8, 1'b1);
        tick();
        chk("stall.done", 64'(done),     64'd1);
        chk("stall.wbv",  64'(wb_valid), 64'd0);
        chk("stall.xv",   64'(xfer_valid), 64'd0);
        tick();

        // LDMIA R2!,{R2,R3}: writeback suppressed
        issue(32'hE8B2000C, 32'h3000);
        tick(); chk_xfer("rnin.x0", 4'd2, 32'h3000, 1'b1);
        tick(); chk_xfer("rnin.x1", 4'd3, 32'h3004, 1'b1);
        tick();
        chk("rnin.wbv",  64'(wb_valid),   64'd0);
        chk("rnin.busy", 64'(busy),       64'd1);
        chk("rnin.xv",   64'(xfer_valid), 64'd0);
        tick();
        chk("rnin.done", 64'(done), 64'd1);
`ifdef LSM_PC_FLUSH_EN
        chk("rnin.flush", 64'(flush), 64'd0);
`endif
        tick();

        // STMDA R5!,{R0,R1,R2} from BASE=4: addresses wrap below zero
        issue(32'hE8250007, 32'h4);
        tick(); chk_xfer("wrap.x0", 4'd0, 32'hFFFFFFFC, 1'b0);
        tick(); chk_xfer("wrap.x1", 4'd1, 32'h0,        1'b0);
        tick(); chk_xfer("wrap.x2", 4'd2, 32'h4,        1'b0);
        tick();
        chk("wrap.wb.v",    64'(wb_valid), 64'd1);
        chk("wrap.wb.reg",  64'(wb_reg),   64'd5);
        chk("wrap.wb.data", 64'(wb_data),  64'hFFFFFFF8);
        tick();
        chk("wrap.done", 64'(done), 64'd1);
        tick();

        // Reset during the second transfer
        issue(32'hE8A00016, 32'h1000);
        tick(); chk_xfer("abort.x0", 4'd1, 32'h1000, 1'b0);
        tick(); chk_xfer("abort.x1", 4'd2, 32'h1004, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy),       64'd0);
        chk("abort.xv",   64'(xfer_valid), 64'd0);
        chk("abort.sel",  64'(reg_sel),    64'd0);
        chk("abort.addr", 64'(addr),       64'd0);
        chk("abort.wbv",  64'(wb_valid),   64'd0);
        chk("abort.done", 64'(done),       64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("abort.post.done", 64'(done),     64'd0);
        chk("abort.post.wbv",  64'(wb_valid), 64'd0);

        // Non-LSM opcode is ignored
        issue(32'hE0810002, 32'h1000);
        chk("nonlsm.busy0", 64'(busy), 64'd0);
        tick();
        chk("nonlsm.busy1", 64'(busy),       64'd0);
        chk("nonlsm.xv",    64'(xfer_valid), 64'd0);
        tick();
        chk("nonlsm.done",  64'(done),       64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
